result_collector: RTL and testbench
===================================

# result_collector

Downstream consumer of the mode/number result stage. Captures each contiguous burst of signed 6-bit results and, once the burst ends, emits a one-cycle summary (max, min, sum, count, overflow). It then replays the buffered samples in reverse order, one per cycle. Sits directly on the result stage's `out_valid`/`out_result` pair and feeds the display/checker logic.

## Interface
- `DEPTH`, 8: max samples buffered per burst; power of two, ≥2.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample strobe; a contiguous high run is one burst.
- `in_result`  in  6  signed sample.
- `out_valid`  out  1  summary strobe, one cycle per burst.
- `out_max`, `out_min`  out  6  signed burst extremes.
- `out_sum`  out  $clog2(DEPTH)+6  signed sum of stored samples (9 bits at DEPTH=8).
- `out_count`  out  $clog2(DEPTH)+1  number of stored samples.
- `out_ovf`  out  1  burst was longer than DEPTH.
- `out_data_valid`  out  1  replay strobe.
- `out_data`  out  6  signed replayed sample.

## Operation
- States are IDLE, COLLECT, REPORT and REPLAY.
- **IDLE**
  - `in_valid`=1: store the sample at slot 0, init max=min=sum=sample, count=1, ovf=0, go to COLLECT.
- **COLLECT**
  - `in_valid`=1 and count<DEPTH: push, update max/min/sum, count+1.
  - `in_valid`=1 and count=DEPTH: drop the sample, set ovf; stats are not updated.
  - `in_valid`=0: go to REPORT.
- **REPORT** (1 cycle)
  - Drive `out_valid`=1 with the registered stats.
  - Go to REPLAY.
- **REPLAY**
  - Pop the LIFO, one sample per cycle, `out_data_valid`=1, for exactly count cycles, newest first.
  - Go to IDLE after the last pop.
- `in_valid` in REPORT/REPLAY is ignored; those samples are lost and no flag is raised.
- Sum arithmetic:
  - sign-extend each sample to the sum width; no saturation is needed.
  - Range is −32·DEPTH..31·DEPTH, which fits the sum width.
- Compare is signed: −32 < 31.
- Outputs are registered. When the corresponding strobe is 0, `out_max`/`out_min`/`out_sum`/`out_count`/`out_ovf`/`out_data` are driven to 0.

## Timing
- Reset (async assert, sync release) values:
  - state = IDLE
  - all outputs = 0
  - count = 0
  - LIFO contents are don't-care.
- A burst of N samples ending with the last `in_valid` at cycle t:
  - `in_valid`=0 is sampled at t+1.
  - `out_valid`=1 at t+2, visible after the edge ending cycle t+1.
  - `out_data_valid`=1 during t+3 .. t+2+min(N,DEPTH).
- IDLE is re-entered the cycle after the last replay word. A burst starting in that cycle is accepted.
- Summary and replay never overlap; `out_valid` and `out_data_valid` are never high together.
- Reset asserted mid-COLLECT/REPORT/REPLAY:
  - outputs go to 0 immediately, state goes to IDLE.
  - no partial summary or replay follows.
- A single-sample burst: REPORT, then exactly one replay cycle.

## Structure
- `result_collector_pkg`:
  - `state_e` enum (IDLE, COLLECT, REPORT, REPLAY)
  - `RES_W`=6
  - width helper functions for sum and count.
- Sub-module `result_lifo`:
  - DEPTH×6 register stack with push, pop, full and empty.
  - Pop on empty is a no-op returning 0; push on full is a no-op.
- Top contains the FSM, stats registers and output registers.

## Test plan
- Burst 3, −5, 7 → summary max=7, min=−5, sum=5, count=3, ovf=0. Replay 7, −5, 3 on three consecutive cycles starting 3 cycles after the last `in_valid`.
- Single sample −32 → max=min=sum=−32, count=1. One replay word −32.
- 10 samples of 31 → count=8, sum=248, ovf=1, max=min=31. Eight replay words of 31.
- 8 samples of −32 → sum=−256 (9'h100), no wrap. Min=max=−32.
- `in_valid` pulsed during REPLAY with value 5 → ignored. Replay unchanged. A new burst started the cycle after replay ends → collected normally.
- `rst` asserted during the second replay word → all outputs 0 within the same cycle, state IDLE. The next burst 1, 2 → max=2, min=1, sum=3, count=2.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared types and width helpers for the result collector.
package result_collector_pkg;

  localparam int unsigned RES_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StReport,
    StReplay
  } state_e;

  // Sum needs log2(depth) extra bits over a sample to hold depth samples without wrap.
  function automatic int unsigned sum_width(input int unsigned depth);
    return $clog2(depth) + RES_W;
  endfunction

  // Count must reach depth itself, hence one bit beyond the index width.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_lifo.sv
// Register stack holding one burst of samples; push on full and pop on empty are no-ops.
module result_lifo
  import result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [RES_W-1:0] din,
  output logic [RES_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [RES_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]  ptr_q;
  logic [IdxW-1:0]  top_idx;
  logic             push_en;
  logic             pop_en;

  assign full    = (ptr_q == PtrW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign push_en = push && !full && !pop;
  assign pop_en  = pop && !empty;
  // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
  assign top_idx = ptr_q[IdxW-1:0] - IdxW'(1);
  assign dout    = empty ? '0 : mem[top_idx];

  // Stack pointer: counts stored entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (push_en) begin
      ptr_q <= ptr_q + PtrW'(1);
    end else if (pop_en) begin
      ptr_q <= ptr_q - PtrW'(1);
    end
  end

  // Storage array; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[ptr_q[IdxW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects bursts of signed results, reports max/min/sum/count/overflow, then replays newest-first.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic signed [RES_W-1:0]              in_result,
  output logic                                 out_valid,
  output logic signed [RES_W-1:0]              out_max,
  output logic signed [RES_W-1:0]              out_min,
  output logic signed [sum_width(DEPTH)-1:0]   out_sum,
  output logic        [cnt_width(DEPTH)-1:0]   out_count,
  output logic                                 out_ovf,
  output logic                                 out_data_valid,
  output logic signed [RES_W-1:0]              out_data
);

  localparam int unsigned SumW = sum_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  state_e state_q, state_d;

  logic signed [RES_W-1:0] max_q, min_q;
  logic signed [SumW-1:0]  sum_q;
  logic        [CntW-1:0]  count_q;
  logic                    ovf_q;

  logic signed [SumW-1:0]  sample_ext;
  logic                    accept_first, accept_more, drop, push, pop;
  logic                    lifo_full, lifo_empty;
  logic        [RES_W-1:0] lifo_top;

  logic                    out_valid_d, out_ovf_d, out_data_valid_d;
  logic signed [RES_W-1:0] out_max_d, out_min_d, out_data_d;
  logic signed [SumW-1:0]  out_sum_d;
  logic        [CntW-1:0]  out_count_d;

  assign sample_ext   = {{(SumW - RES_W){in_result[RES_W-1]}}, in_result};
  assign accept_first = (state_q == StIdle) && in_valid;
  assign accept_more  = (state_q == StCollect) && in_valid && !lifo_full;
  assign drop         = (state_q == StCollect) && in_valid && lifo_full;
  assign push         = accept_first || accept_more;
  // REPORT pops the first word so replay data lands the cycle after the summary.
  assign pop          = (state_q == StReport) || ((state_q == StReplay) && !lifo_empty);

  result_lifo #(
    .DEPTH(DEPTH)
  ) u_lifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (in_result),
    .dout (lifo_top),
    .full (lifo_full),
    .empty(lifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in_valid outside IDLE/COLLECT is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid) state_d = StCollect;
      StCollect: if (!in_valid) state_d = StReport;
      StReport:  state_d = StReplay;
      StReplay:  if (lifo_empty) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Burst statistics; overflowing samples only raise the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      min_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept_first) begin
      max_q   <= in_result;
      min_q   <= in_result;
      sum_q   <= sample_ext;
      count_q <= CntW'(1);
      ovf_q   <= 1'b0;
    end else if (accept_more) begin
      if (in_result > max_q) max_q <= in_result;
      if (in_result < min_q) min_q <= in_result;
      sum_q   <= sum_q + sample_ext;
      count_q <= count_q + CntW'(1);
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  // Output next values: data fields are zero whenever their strobe is low.
  always_comb begin
    out_valid_d      = 1'b0;
    out_max_d        = '0;
    out_min_d        = '0;
    out_sum_d        = '0;
    out_count_d      = '0;
    out_ovf_d        = 1'b0;
    out_data_valid_d = 1'b0;
    out_data_d       = '0;
    if ((state_q == StCollect) && !in_valid) begin
      out_valid_d = 1'b1;
      out_max_d   = max_q;
      out_min_d   = min_q;
      out_sum_d   = sum_q;
      out_count_d = count_q;
      out_ovf_d   = ovf_q;
    end
    if (pop) begin
      out_data_valid_d = 1'b1;
      out_data_d       = lifo_top;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_max        <= '0;
      out_min        <= '0;
      out_sum        <= '0;
      out_count      <= '0;
      out_ovf        <= 1'b0;
      out_data_valid <= 1'b0;
      out_data       <= '0;
    end else begin
      out_valid      <= out_valid_d;
      out_max        <= out_max_d;
      out_min        <= out_min_d;
      out_sum        <= out_sum_d;
      out_count      <= out_count_d;
      out_ovf        <= out_ovf_d;
      out_data_valid <= out_data_valid_d;
      out_data       <= out_data_d;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed cases plus random bursts against a burst-level model.
module tb_result_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SUM_W = 9;
  localparam int unsigned CNT_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic signed [5:0]       in_result;
  logic                    out_valid;
  logic signed [5:0]       out_max, out_min;
  logic signed [SUM_W-1:0] out_sum;
  logic        [CNT_W-1:0] out_count;
  logic                    out_ovf;
  logic                    out_data_valid;
  logic signed [5:0]       out_data;

  int n_checks = 0;
  int n_errors = 0;
  int burst_q[$];

  result_collector #(
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_result     (in_result),
    .out_valid     (out_valid),
    .out_max       (out_max),
    .out_min       (out_min),
    .out_sum       (out_sum),
    .out_count     (out_count),
    .out_ovf       (out_ovf),
    .out_data_valid(out_data_valid),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input integer obs, input integer exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_max"}, out_max, 0);
    check({tag, "_min"}, out_min, 0);
    check({tag, "_sum"}, out_sum, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_ovf"}, out_ovf, 0);
    check({tag, "_dvalid"}, out_data_valid, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives burst_q on consecutive cycles and checks the summary and the reversed replay.
  // poke: hold in_valid=5 throughout replay (must be ignored).
  // rst_at: replay word index at which reset is asserted, or -1.
  task automatic run_burst(input bit poke, input int rst_at);
    int n, m, emax, emin, esum, eovf;
    int v;
    n = burst_q.size();
    m = (n < DEPTH) ? n : DEPTH;
    emax = -1000;
    emin = 1000;
    esum = 0;
    for (int i = 0; i < m; i++) begin
      if (burst_q[i] > emax) emax = burst_q[i];
      if (burst_q[i] < emin) emin = burst_q[i];
      esum += burst_q[i];
    end
    eovf = (n > DEPTH) ? 1 : 0;

    for (int i = 0; i < n; i++) begin
      v = burst_q[i];
      in_valid  = 1'b1;
      in_result = v[5:0];
      tick();
      check("collect_quiet", {out_valid, out_data_valid}, 0);
    end
    in_valid  = 1'b0;
    in_result = '0;
    tick();
    check("sum_valid", out_valid, 1);
    check("sum_max", out_max, emax);
    check("sum_min", out_min, emin);
    check("sum_sum", out_sum, esum);
    check("sum_count", out_count, m);
    check("sum_ovf", out_ovf, eovf);
    check("sum_no_data", out_data_valid, 0);

    for (int k = 0; k < m; k++) begin
      tick();
      check("replay_valid", out_data_valid, 1);
      check("replay_data", out_data, burst_q[m-1-k]);
      check("replay_no_sum", out_valid, 0);
      if (k == rst_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          tick();
          check_all_zero("post_rst");
        end
        return;
      end
      if (poke) begin
        in_valid  = 1'b1;
        in_result = 6'sd5;
      end
    end
    in_valid  = 1'b0;
    in_result = '0;
    tick();
    check("replay_end_valid", out_data_valid, 0);
    check("replay_end_data", out_data, 0);
    check("replay_end_sum", out_valid, 0);
  endtask

  initial begin
    int len, gap;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    burst_q = {3, -5, 7};
    run_burst(1'b0, -1);
    tick();

    burst_q = {-32};
    run_burst(1'b0, -1);

    burst_q = {};
    repeat (10) burst_q.push_back(31);
    run_burst(1'b0, -1);

    burst_q = {};
    repeat (8) burst_q.push_back(-32);
    run_burst(1'b0, -1);

    // Inputs during replay are dropped; the next burst starts the cycle replay ends.
    burst_q = {10, -20, 4, 0};
    run_burst(1'b1, -1);
    burst_q = {-1, 6};
    run_burst(1'b0, -1);

    // Reset during the second replay word.
    burst_q = {12, -7, 30, 2};
    run_burst(1'b0, 1);
    burst_q = {1, 2};
    run_burst(1'b0, -1);

    for (int b = 0; b < 40; b++) begin
      len = int'($urandom_range(1, 12));
      burst_q = {};
      for (int i = 0; i < len; i++) burst_q.push_back(int'($urandom_range(0, 63)) - 32);
      run_burst(1'($urandom_range(0, 1)), -1);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_quiet", {out_valid, out_data_valid}, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
